// File: rtl/mcu51_pkg.sv
// Shared MCU51 definitions: interrupt source order, vector table, IE/IP bit
// positions and the interrupt controller state type.
package mcu51_pkg;

    localparam int unsigned NUM_SRC = 5;

    localparam logic [2:0] SRC_INT0 = 3'd0;
    localparam logic [2:0] SRC_T0   = 3'd1;
    localparam logic [2:0] SRC_INT1 = 3'd2;
    localparam logic [2:0] SRC_T1   = 3'd3;
    localparam logic [2:0] SRC_SER  = 3'd4;

    localparam int unsigned IE_EA  = 7;
    localparam int unsigned IE_ES  = 4;
    localparam int unsigned IE_ET1 = 3;
    localparam int unsigned IE_EX1 = 2;
    localparam int unsigned IE_ET0 = 1;
    localparam int unsigned IE_EX0 = 0;

    localparam logic [7:0] INT_VEC [0:4] = '{8'h03, 8'h0B, 8'h13, 8'h1B, 8'h23};

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        REQ
    } int_st_t;

    // Lowest set index wins; returns 0 for an empty vector.
    function automatic logic [2:0] lowest_idx(input logic [NUM_SRC-1:0] v);
        logic found;
        lowest_idx = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (v[i] && !found) begin
                lowest_idx = 3'(i);
                found      = 1'b1;
            end
        end
    endfunction

    // svc = {high_active, low_active}; a high request is blocked only by high.
    function automatic logic level_blocked(input logic lvl, input logic [1:0] svc);
        return svc[1] | (~lvl & svc[0]);
    endfunction

endpackage

// File: rtl/int_edge_det.sv
// External interrupt pin flag: falling-edge latch with set-over-clear priority,
// or a registered level follower when edge mode is off.
module int_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic pin_n_i,
    input  logic edge_mode_i,
    input  logic clr_i,
    output logic flag_o
);

    logic dly_q;
    logic flag_q, flag_d;

    always_comb begin
        flag_d = flag_q;
        if (!edge_mode_i) begin
            flag_d = ~pin_n_i;
        end else if (dly_q & ~pin_n_i) begin
            flag_d = 1'b1;
        end else if (clr_i) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dly_q  <= 1'b1;
            flag_q <= 1'b0;
        end else begin
            dly_q  <= pin_n_i;
            flag_q <= flag_d;
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/int_ctrl.sv
// MCU51 interrupt controller: pending/priority resolution, LCALL request FSM
// and in-service level tracking until RETI.
module int_ctrl
    import mcu51_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       poll,
    input  logic       instr_last,
    input  logic       is_reti,
    input  logic       blk_wr,
    input  logic       int0_n,
    input  logic       int1_n,
    input  logic       it0,
    input  logic       it1,
    input  logic       tf0,
    input  logic       tf1,
    input  logic       ri,
    input  logic       ti,
    input  logic [7:0] ie,
    input  logic [7:0] ip,
    input  logic       int_ack,
    output logic       int_req,
    output logic [7:0] vector,
    output logic       ie0,
    output logic       ie1,
    output logic       clr_tf0,
    output logic       clr_tf1,
    output logic [1:0] in_svc
);

    int_st_t            state_q, state_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [2:0]         idx_q, idx_d;
    logic               lvl_q, lvl_d;
    logic               hold_q, hold_d;
    logic [1:0]         svc_q, svc_d;
    logic               int_req_q, int_req_d;
    logic [7:0]         vector_q, vector_d;
    logic               clr_tf0_q, clr_tf0_d;
    logic               clr_tf1_q, clr_tf1_d;

    logic               ie0_w, ie1_w;
    logic               ack_fire;
    logic [NUM_SRC-1:0] pend_now, hi_pend;
    logic               sel_lvl;
    logic [2:0]         sel_idx;
    logic               unused_sfr_bits;

    assign unused_sfr_bits = ^{ie[6:5], ip[7:5]};

    assign ack_fire = (state_q == REQ) && int_ack;

    int_edge_det u_edge0 (
        .clk         (clk),
        .reset       (reset),
        .pin_n_i     (int0_n),
        .edge_mode_i (it0),
        .clr_i       (ack_fire && (idx_q == SRC_INT0)),
        .flag_o      (ie0_w)
    );

    int_edge_det u_edge1 (
        .clk         (clk),
        .reset       (reset),
        .pin_n_i     (int1_n),
        .edge_mode_i (it1),
        .clr_i       (ack_fire && (idx_q == SRC_INT1)),
        .flag_o      (ie1_w)
    );

    assign pend_now = {ri | ti, tf1, ie1_w, tf0, ie0_w} & ie[NUM_SRC-1:0]
                      & {NUM_SRC{ie[IE_EA]}};
    assign hi_pend  = pend_q & ip[NUM_SRC-1:0];
    assign sel_lvl  = |hi_pend;
    assign sel_idx  = lowest_idx(sel_lvl ? hi_pend : pend_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lvl_d     = lvl_q;
        int_req_d = int_req_q;
        vector_d  = vector_q;
        clr_tf0_d = 1'b0;
        clr_tf1_d = 1'b0;
        pend_d    = poll ? pend_now : pend_q;
        hold_d    = instr_last ? (is_reti | blk_wr) : hold_q;
        svc_d     = svc_q;

        if (instr_last && is_reti) begin
            if (svc_q[1]) svc_d[1] = 1'b0;
            else          svc_d[0] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (poll && (|pend_q) && !hold_q && !level_blocked(sel_lvl, svc_q)) begin
                    state_d = ARM;
                    idx_d   = sel_idx;
                    lvl_d   = sel_lvl;
                end
            end
            ARM: begin
                // A RETI or IE/IP write finishing now counts as a fresh block.
                if (instr_last) begin
                    if ((|pend_q) && !level_blocked(lvl_q, svc_q) && !(is_reti | blk_wr)) begin
                        state_d   = REQ;
                        int_req_d = 1'b1;
                        vector_d  = INT_VEC[idx_q];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_d      = IDLE;
                    int_req_d    = 1'b0;
                    svc_d[lvl_q] = 1'b1;
                    clr_tf0_d    = (idx_q == SRC_T0);
                    clr_tf1_d    = (idx_q == SRC_T1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            idx_q     <= '0;
            lvl_q     <= 1'b0;
            hold_q    <= 1'b0;
            svc_q     <= '0;
            int_req_q <= 1'b0;
            vector_q  <= '0;
            clr_tf0_q <= 1'b0;
            clr_tf1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            idx_q     <= idx_d;
            lvl_q     <= lvl_d;
            hold_q    <= hold_d;
            svc_q     <= svc_d;
            int_req_q <= int_req_d;
            vector_q  <= vector_d;
            clr_tf0_q <= clr_tf0_d;
            clr_tf1_q <= clr_tf1_d;
        end
    end

    assign int_req = int_req_q;
    assign vector  = vector_q;
    assign ie0     = ie0_w;
    assign ie1     = ie1_w;
    assign clr_tf0 = clr_tf0_q;
    assign clr_tf1 = clr_tf1_q;
    assign in_svc  = svc_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: expected vectors are queued with the stimulus
// and popped when the controller raises int_req.
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       reset, poll, instr_last, is_reti, blk_wr;
    logic       int0_n, int1_n, it0, it1, tf0, tf1, ri, ti;
    logic [7:0] ie, ip;
    logic       int_ack;
    logic       int_req;
    logic [7:0] vector;
    logic       ie0, ie1, clr_tf0, clr_tf1;
    logic [1:0] in_svc;

    int         n_vec = 0;
    int         n_err = 0;
    int         req_cycles = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    int_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .poll       (poll),
        .instr_last (instr_last),
        .is_reti    (is_reti),
        .blk_wr     (blk_wr),
        .int0_n     (int0_n),
        .int1_n     (int1_n),
        .it0        (it0),
        .it1        (it1),
        .tf0        (tf0),
        .tf1        (tf1),
        .ri         (ri),
        .ti         (ti),
        .ie         (ie),
        .ip         (ip),
        .int_ack    (int_ack),
        .int_req    (int_req),
        .vector     (vector),
        .ie0        (ie0),
        .ie1        (ie1),
        .clr_tf0    (clr_tf0),
        .clr_tf1    (clr_tf1),
        .in_svc     (in_svc)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (int_req) req_cycles++;
    endtask

    // One instruction of ncyc machine cycles (4 clks each); instr_last in clk 1
    // of the last cycle, poll in clk 3 of every cycle.
    task automatic instr(input int ncyc, input bit reti, input bit bw);
        for (int c = 0; c < ncyc; c++) begin
            for (int t = 0; t < 4; t++) begin
                instr_last = (c == ncyc - 1) && (t == 1);
                is_reti    = instr_last & reti;
                blk_wr     = instr_last & bw;
                poll       = (t == 3);
                tick();
            end
        end
        instr_last = 1'b0;
        is_reti    = 1'b0;
        blk_wr     = 1'b0;
        poll       = 1'b0;
    endtask

    // Run instructions until int_req, compare against the queue head, then ack.
    task automatic service(input int max_instr, input bit do_ack, input logic [1:0] exp_svc);
        int         n;
        logic [7:0] exp_v;
        n = 0;
        while (!int_req && n < max_instr) begin
            instr(2, 1'b0, 1'b0);
            n++;
        end
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hFF;
        chk("req_raised", {7'd0, int_req}, 8'd1);
        chk("vector", vector, exp_v);
        if (do_ack && int_req) begin
            int_ack = 1'b1;
            tick();
            int_ack = 1'b0;
            chk("req_drop", {7'd0, int_req}, 8'd0);
            chk("clr_tf0", {7'd0, clr_tf0}, {7'd0, exp_v == 8'h0B});
            chk("clr_tf1", {7'd0, clr_tf1}, {7'd0, exp_v == 8'h1B});
            chk("in_svc_ack", {6'd0, in_svc}, {6'd0, exp_svc});
            tick();
            chk("clr_pulse_end", {6'd0, clr_tf1, clr_tf0}, 8'd0);
        end
    endtask

    initial begin
        int r0;
        reset = 1'b1; poll = 1'b0; instr_last = 1'b0; is_reti = 1'b0; blk_wr = 1'b0;
        int0_n = 1'b1; int1_n = 1'b1; it0 = 1'b1; it1 = 1'b1;
        tf0 = 1'b0; tf1 = 1'b0; ri = 1'b0; ti = 1'b0;
        ie = 8'h00; ip = 8'h00; int_ack = 1'b0;
        repeat (3) tick();
        chk("rst_req", {7'd0, int_req}, 8'd0);
        chk("rst_vector", vector, 8'h00);
        chk("rst_flags", {4'd0, ie1, ie0, clr_tf1, clr_tf0}, 8'd0);
        chk("rst_svc", {6'd0, in_svc}, 8'd0);
        reset = 1'b0;
        tick();

        // T0, low priority, exact request timing
        ie = 8'h82; tf0 = 1'b1;
        exp_q.push_back(8'h0B);
        instr(2, 1'b0, 1'b0);
        chk("t0_not_yet", {7'd0, int_req}, 8'd0);
        instr(2, 1'b0, 1'b0);
        chk("t0_req_now", {7'd0, int_req}, 8'd1);
        service(1, 1'b1, 2'b01);
        tf0 = 1'b0;
        instr(2, 1'b1, 1'b0);
        chk("t0_reti", {6'd0, in_svc}, 8'd0);
        repeat (2) instr(2, 1'b0, 1'b0);

        // INT1 high beats INT0 low; INT0 waits for RETI plus one instruction
        ie = 8'h85; ip = 8'h04;
        int0_n = 1'b0; int1_n = 1'b0;
        tick(); tick();
        int0_n = 1'b1; int1_n = 1'b1;
        exp_q.push_back(8'h13);
        service(4, 1'b1, 2'b10);
        chk("ie0_kept", {7'd0, ie0}, 8'd1);
        chk("ie1_cleared", {7'd0, ie1}, 8'd0);
        r0 = req_cycles;
        repeat (3) instr(2, 1'b0, 1'b0);
        chk("low_blk_by_hi", 8'(req_cycles - r0), 8'd0);
        instr(2, 1'b1, 1'b0);
        chk("reti_hi", {6'd0, in_svc}, 8'd0);
        chk("reti_hold", {7'd0, int_req}, 8'd0);
        exp_q.push_back(8'h03);
        service(6, 1'b1, 2'b01);
        chk("ie0_cleared", {7'd0, ie0}, 8'd0);
        instr(2, 1'b1, 1'b0);
        repeat (2) instr(2, 1'b0, 1'b0);

        // nesting: low T0 active, high INT0 nests, second low waits for both RETIs
        ie = 8'h83; ip = 8'h01; tf0 = 1'b1;
        exp_q.push_back(8'h0B);
        service(4, 1'b1, 2'b01);
        tf0 = 1'b0;
        int0_n = 1'b0; tick(); tick(); int0_n = 1'b1;
        exp_q.push_back(8'h03);
        service(4, 1'b1, 2'b11);
        tf0 = 1'b1;
        r0 = req_cycles;
        repeat (3) instr(2, 1'b0, 1'b0);
        instr(2, 1'b1, 1'b0);
        chk("nest_reti1", {6'd0, in_svc}, 8'd1);
        repeat (3) instr(2, 1'b0, 1'b0);
        chk("nest_blocked", 8'(req_cycles - r0), 8'd0);
        instr(2, 1'b1, 1'b0);
        chk("nest_reti2", {6'd0, in_svc}, 8'd0);
        exp_q.push_back(8'h0B);
        service(6, 1'b1, 2'b01);
        tf0 = 1'b0;
        instr(2, 1'b1, 1'b0);
        repeat (2) instr(2, 1'b0, 1'b0);

        // IE/IP write at the boundary defers T1
        ie = 8'h88; ip = 8'h00; tf1 = 1'b1;
        instr(2, 1'b0, 1'b0);
        instr(2, 1'b0, 1'b1);
        chk("blkwr_noreq", {7'd0, int_req}, 8'd0);
        exp_q.push_back(8'h1B);
        service(4, 1'b1, 2'b01);
        tf1 = 1'b0;
        instr(2, 1'b1, 1'b0);
        repeat (2) instr(2, 1'b0, 1'b0);

        // level-mode INT0 released before the boundary
        ie = 8'h81; it0 = 1'b0; int0_n = 1'b0;
        r0 = req_cycles;
        instr(2, 1'b0, 1'b0);
        chk("lvl_ie0", {7'd0, ie0}, 8'd1);
        int0_n = 1'b1;
        instr(3, 1'b0, 1'b0);
        repeat (2) instr(2, 1'b0, 1'b0);
        chk("lvl_noreq", 8'(req_cycles - r0), 8'd0);
        chk("lvl_ie0_off", {7'd0, ie0}, 8'd0);

        // reset while a nested request is outstanding
        it0 = 1'b1; ie = 8'h83; ip = 8'h02;
        int0_n = 1'b0; tick(); tick(); int0_n = 1'b1;
        exp_q.push_back(8'h03);
        service(4, 1'b1, 2'b01);
        tf0 = 1'b1;
        exp_q.push_back(8'h0B);
        service(4, 1'b0, 2'b00);
        reset = 1'b1;
        tick();
        chk("rstreq_req", {7'd0, int_req}, 8'd0);
        chk("rstreq_svc", {6'd0, in_svc}, 8'd0);
        chk("rstreq_clr", {6'd0, clr_tf1, clr_tf0}, 8'd0);
        tick();
        chk("rstreq_clr2", {6'd0, clr_tf1, clr_tf0}, 8'd0);
        reset = 1'b0; tf0 = 1'b0;
        tick();

        chk("queue_empty", 8'(exp_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
